// File: rtl/burst_read_slave_if.sv
// Bus-side signal bundle of the burst read/write slave; the bus is OR-combined,
// so every slave output is 0 whenever the slave is not driving it.
interface burst_read_slave_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;

    modport slave (
        input  beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );

    modport master (
        output beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );
endinterface

// File: rtl/burst_read_slave.sv
// Memory-backed burst slave: decodes a start address, streams read beats after
// WAIT_STATES cycles, accepts byte-enabled write beats, and has a side preload port.
module burst_read_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
    parameter int          NR_OF_WORDS  = 1024,
    parameter int          WAIT_STATES  = 2
) (
    input  logic                clock,
    input  logic                reset,
    burst_read_slave_if.slave   bus,
    input  logic                loadEnable,
    input  logic [15:0]         loadAddress,
    input  logic [31:0]         loadData
);
    localparam int          IDX_W = (NR_OF_WORDS > 1) ? $clog2(NR_OF_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(NR_OF_WORDS) * 33'd4;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;
    localparam logic [2:0] S_ENDR   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [7:0]       burst_q, burst_d;
    logic             rnw_q, rnw_d;
    logic [3:0]       be_q, be_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [3:0]       wait_q, wait_d;

    logic [31:0]      mem [NR_OF_WORDS];
    logic [31:0]      offset;
    logic             in_range;
    logic             bus_we;
    logic [IDX_W-1:0] load_idx;
    logic             unused_load_bits;

    // Range test uses 33-bit span so BASE_ADDRESS near the top of the map cannot overflow.
    assign offset   = addr_q - BASE_ADDRESS;
    assign in_range = (addr_q >= BASE_ADDRESS) && ({1'b0, offset} < SPAN) &&
                      (addr_q[1:0] == 2'b00);
    assign load_idx = loadAddress[IDX_W-1:0];
    assign unused_load_bits = ^loadAddress;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        state_d = state_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        rnw_d   = rnw_q;
        be_d    = be_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        bus_we  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.beginTransactionIn) begin
                addr_d  = bus.addressDataIn;
                burst_d = bus.burstSizeIn;
                rnw_d   = bus.readNotWriteIn;
                be_d    = bus.byteEnablesIn;
                cnt_d   = '0;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                idx_d = offset[IDX_W+1:2];
                if (!in_range)        state_d = S_ERROR;
                else if (!rnw_q)      state_d = S_WRITE;
                else if (WS == 4'd0)  state_d = S_READ;
                else begin
                    wait_d  = WS - 4'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.endTransactionIn) state_d = S_IDLE;
                else if (wait_q == 4'd0)  state_d = S_READ;
                else                      wait_d  = wait_q - 4'd1;
            end
            S_READ: begin
                if (bus.endTransactionIn) state_d = S_IDLE;
                else begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == {1'b0, burst_q}) state_d = S_ENDR;
                end
            end
            S_WRITE: begin
                // Beats past burst+1 are dropped but the burst stays open until the master ends it.
                if (bus.dataValidIn && (cnt_q <= {1'b0, burst_q})) begin
                    bus_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    cnt_d  = cnt_q + 9'd1;
                end
                if (bus.endTransactionIn) state_d = S_IDLE;
            end
            S_ERROR: if (rnw_q || bus.endTransactionIn) state_d = S_IDLE;
            S_ENDR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            burst_q <= '0;
            rnw_q   <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            rnw_q   <= rnw_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // NOTE: the memory array is deliberately left out of reset; it keeps contents across reset.
    always_ff @(posedge clock) begin
        if (loadEnable && !(bus_we && (load_idx == idx_q)))
            mem[load_idx] <= loadData;
        if (bus_we) begin
            for (int b = 0; b < 4; b++)
                if (be_q[b]) mem[idx_q][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    assign bus.dataValidOut      = (state_q == S_READ);
    assign bus.addressDataOut    = (state_q == S_READ) ? mem[idx_q] : 32'h0;
    assign bus.endTransactionOut = (state_q == S_ENDR) || ((state_q == S_ERROR) && rnw_q);
    assign bus.busErrorOut       = (state_q == S_ERROR);
endmodule

// File: tb/tb_burst_read_slave.sv
// Randomised scoreboard bench for burst_read_slave: a word-array model predicts
// every read beat, its cycle, and the closing/error pulse.
module tb_burst_read_slave;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          WORDS = 1024;
    localparam int          WS    = 2;

    typedef enum int {K_BEAT = 0, K_END = 1, K_ERR = 2} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        loadEnable;
    logic [15:0] loadAddress;
    logic [31:0] loadData;

    burst_read_slave_if bus();

    burst_read_slave #(.BASE_ADDRESS(BASE), .NR_OF_WORDS(WORDS), .WAIT_STATES(WS)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .loadEnable  (loadEnable),
        .loadAddress (loadAddress),
        .loadData    (loadData)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          wr_err = 1'b0;
    exp_t        sb[$];
    logic [31:0] wq[$];
    logic [31:0] model_mem [WORDS];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT output event is matched against the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (bus.dataValidOut) begin
            check("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("beat_kind", 32'(K_BEAT), 32'(e.kind));
                check("beat_data", bus.addressDataOut, e.data);
                check("beat_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("idle_data_zero", bus.addressDataOut, 32'h0);
        end
        if (bus.endTransactionOut) begin
            check("end_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("end_kind", 32'(bus.busErrorOut ? K_ERR : K_END), 32'(e.kind));
                check("end_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (bus.busErrorOut) begin
            check("stray_bus_error", 32'(wr_err), 32'd1);
        end
    end

    function automatic bit in_range(input logic [31:0] a);
        longint la = longint'(a);
        longint lb = longint'(BASE);
        return (la >= lb) && (la < lb + 4 * WORDS) && (a[1:0] == 2'b00);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        return int'(off >> 2);
    endfunction

    function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        loadEnable  = 1'b1;
        loadAddress = 16'(idx);
        loadData    = d;
        model_mem[idx % WORDS] = d;
        tick();
        loadEnable = 1'b0;
    endtask

    task automatic begin_txn(input logic [31:0] addr, input bit rnw, input int burst,
                             input logic [3:0] be);
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = addr;
        bus.readNotWriteIn     = rnw;
        bus.burstSizeIn        = 8'(burst);
        bus.byteEnablesIn      = be;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.addressDataIn      = 32'h0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        tick();
    endtask

    // Read burst; abort_k >= 0 raises endTransactionIn during beat abort_k.
    task automatic do_read(input logic [31:0] addr, input int burst, input int abort_k,
                           input bit stray);
        int  n    = cyc;
        bit  ok   = in_range(addr);
        int  idx  = word_of(addr);
        int  last = (abort_k >= 0) ? abort_k : burst;
        if (ok) begin
            for (int k = 0; k <= last; k++)
                sb.push_back('{K_BEAT, model_mem[(idx + k) % WORDS], n + WS + 2 + k});
            if (abort_k < 0) sb.push_back('{K_END, 32'h0, n + WS + 3 + burst});
        end else begin
            sb.push_back('{K_ERR, 32'h0, n + 2});
        end
        begin_txn(addr, 1'b1, burst, 4'hF);
        if (stray) begin
            tick();
            begin_txn(32'h3FFF_FFFC, 1'b1, 0, 4'hF);
        end
        if (ok && abort_k >= 0) begin
            while (cyc < n + WS + 2 + abort_k) tick();
            bus.endTransactionIn = 1'b1;
            tick();
            bus.endTransactionIn = 1'b0;
        end
        drain();
    endtask

    // Write burst with the beats queued in wq.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int burst,
                            input bit end_sep, input bit collide);
        bit ok  = in_range(addr);
        int idx = word_of(addr);
        begin_txn(addr, 1'b0, burst, be);
        tick();
        if (!ok) begin
            wr_err = 1'b1;
            check("werr_flag", 32'(bus.busErrorOut), 32'd1);
        end
        for (int i = 0; i < wq.size(); i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            bus.dataValidIn   = 1'b1;
            bus.addressDataIn = wq[i];
            if (collide && i == 0) begin
                loadEnable  = 1'b1;
                loadAddress = 16'(idx);
                loadData    = ~wq[i];
            end
            if (ok && i <= burst) model_write((idx + i) % WORDS, wq[i], be);
            if (i == wq.size() - 1 && !end_sep) bus.endTransactionIn = 1'b1;
            tick();
            bus.dataValidIn      = 1'b0;
            bus.endTransactionIn = 1'b0;
            bus.addressDataIn    = 32'h0;
            loadEnable           = 1'b0;
        end
        if (end_sep) begin
            bus.endTransactionIn = 1'b1;
            tick();
            bus.endTransactionIn = 1'b0;
        end
        if (!ok) begin
            check("werr_cleared", 32'(bus.busErrorOut), 32'd0);
            wr_err = 1'b0;
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, sel, burst, abort_k, nb;
        logic [31:0] addr, newv;
        bus.beginTransactionIn = 1'b0;
        bus.addressDataIn      = 32'h0;
        bus.readNotWriteIn     = 1'b0;
        bus.burstSizeIn        = 8'h0;
        bus.byteEnablesIn      = 4'h0;
        bus.dataValidIn        = 1'b0;
        bus.endTransactionIn   = 1'b0;
        loadEnable             = 1'b0;
        loadAddress            = 16'h0;
        loadData               = 32'h0;

        #3;
        check("rst_valid",  32'(bus.dataValidOut), 32'd0);
        check("rst_data",   bus.addressDataOut, 32'h0);
        check("rst_end",    32'(bus.endTransactionOut), 32'd0);
        check("rst_buserr", 32'(bus.busErrorOut), 32'd0);

        // Preload happens under reset: the load port is independent of the bus FSM.
        tick();
        for (int i = 0; i < WORDS; i++) load_word(i, $urandom());
        for (int i = 0; i < 4; i++) load_word(i, 32'(i + 1));
        reset = 1'b1;

        do_read(BASE, 3, -1, 1'b0);
        do_read(BASE + 32'hFFC, 1, -1, 1'b0);
        do_read(32'h3FFF_FFFC, 0, -1, 1'b0);

        wq = '{32'hAABB_CCDD, 32'h1122_3344};
        do_write(BASE + 32'h10, 4'b0011, 1, 1'b1, 1'b0);
        do_read(BASE + 32'h10, 1, -1, 1'b0);

        wq = '{$urandom()};
        do_write(BASE + 32'h40, 4'hF, 0, 1'b0, 1'b1);
        do_read(BASE + 32'h40, 0, -1, 1'b0);

        wq = '{$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        do_write(BASE + 32'h80, 4'hF, 2, 1'b0, 1'b0);
        do_read(BASE + 32'h80, 4, -1, 1'b0);

        wq = '{$urandom()};
        do_write(BASE + 32'h22, 4'hF, 0, 1'b0, 1'b0);
        do_read(BASE + 32'h20, 1, -1, 1'b0);

        do_read(BASE + 32'h100, 7, 2, 1'b0);
        do_read(BASE + 32'h100, 0, -1, 1'b0);
        do_read(BASE + 32'h200, 3, -1, 1'b1);
        do_write(BASE + 32'hFFC, 4'hF, 1, 1'b0, 1'b0);
        do_read(BASE + 32'hFF8, 3, -1, 1'b0);

        // A word loaded during the last wait cycle must appear on the first beat.
        n    = cyc;
        newv = $urandom();
        model_mem[50] = newv;
        for (int k = 0; k < 2; k++) sb.push_back('{K_BEAT, model_mem[50 + k], n + WS + 2 + k});
        sb.push_back('{K_END, 32'h0, n + WS + 4});
        begin_txn(BASE + 32'd200, 1'b1, 1, 4'hF);
        tick();
        load_word(50, newv);
        drain();

        // Reset in the middle of beat 3 of a burst-7 read.
        n = cyc;
        for (int k = 0; k < 8; k++) sb.push_back('{K_BEAT, model_mem[20 + k], n + WS + 2 + k});
        sb.push_back('{K_END, 32'h0, n + WS + 10});
        begin_txn(BASE + 32'd80, 1'b1, 7, 4'hF);
        while (cyc < n + WS + 5) tick();
        #1;
        check("pre_reset_valid", 32'(bus.dataValidOut), 32'd1);
        sb.delete();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.dataValidOut), 32'd0);
        check("mid_rst_data",  bus.addressDataOut, 32'h0);
        check("mid_rst_end",   32'(bus.endTransactionOut), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        do_read(BASE + 32'd80, 7, -1, 1'b0);

        for (int it = 0; it < 30; it++) begin
            sel   = $urandom_range(0, 9);
            burst = $urandom_range(0, 12);
            case (sel)
                0:       addr = BASE - 32'($urandom_range(1, 64)) * 32'd4;
                1:       addr = BASE + 32'(WORDS) * 32'd4 + 32'($urandom_range(0, 64)) * 32'd4;
                2:       addr = BASE + 32'($urandom_range(0, WORDS - 1)) * 32'd4 +
                                32'($urandom_range(1, 3));
                default: addr = BASE + 32'($urandom_range(0, WORDS - 1)) * 32'd4;
            endcase
            if ($urandom_range(0, 2) != 0) begin
                abort_k = ($urandom_range(0, 4) == 0 && burst > 0) ?
                          int'($urandom_range(0, burst - 1)) : -1;
                do_read(addr, burst, abort_k, 1'b0);
            end else begin
                burst = $urandom_range(0, 4);
                nb    = burst + 1 + (($urandom_range(0, 3) == 0) ? 2 : 0);
                wq.delete();
                for (int i = 0; i < nb; i++) wq.push_back($urandom());
                do_write(addr, 4'($urandom_range(1, 15)), burst, 1'($urandom_range(0, 1)), 1'b0);
                if (in_range(addr)) do_read(addr, burst + 1, -1, 1'b0);
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
